instr_encoder_loader: RTL and testbench
=======================================

Name: instr_encoder_loader

Overview:
- Encodes a stream of field-level instruction descriptors into 32-bit RV32I machine words and writes them sequentially into instruction memory.
- This is the inverse of the core's control/decode path. It covers exactly the opcode and funct3 set the control unit decodes: R-type ALU, I-type ALU, lw, sw, and beq/bne/blt.
- It is used by the boot/test infrastructure to load programs into imem before the single-cycle core is released from reset.

Parameters:
- ADDR_W, 8, imem word-address width; the address wraps modulo 2^ADDR_W.
- DEPTH, 256, maximum words written per program. Must satisfy DEPTH <= 2^ADDR_W.

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  one-cycle pulse that begins a load session
- base_addr  in  ADDR_W  first imem word address; latched on accepted start
- in_valid  in  1  descriptor valid
- in_ready  out  1  descriptor accepted when in_valid & in_ready
- in_op  in  7  opcode
- in_funct3  in  3  funct3; forced to 010 for lw and sw
- in_funct7b5  in  1  funct7 bit 5; used for R-type only
- in_rd, in_rs1, in_rs2  in  5 each  register indices
- in_imm  in  13  signed immediate; I and S types use [11:0], B type uses [12:1]
- in_last  in  1  marks the final descriptor of the program
- imem_we  out  1  write request
- imem_ready  in  1  imem accepts the write when imem_we & imem_ready
- imem_addr  out  ADDR_W  word address
- imem_wdata  out  32  encoded instruction
- busy  out  1  high in RUN
- done  out  1  level, high in DONE
- ovf  out  1  DONE was reached because DEPTH words were written, not because of in_last
- err  out  1  one-cycle pulse when an illegal descriptor is dropped
- err_cnt  out  8  saturating count of illegal descriptors
- words_written  out  ADDR_W+1  count of completed imem writes

Behaviour:
- Reset (synchronous, rst_n=0 at a clock edge):
  - state=IDLE; every output is 0, including in_ready, imem_we, imem_addr, imem_wdata, counters and flags.
  - A pending write is discarded. Reset taken mid-session is the abort mechanism.
- FSM states: IDLE, RUN, DONE.
  - IDLE/DONE -> RUN on start. This latches base_addr, clears words_written, err_cnt and ovf, and drops done.
  - start is ignored in RUN.
- RUN handshake:
  - in_ready = !pend_v | (imem_we & imem_ready), gated low after in_last has been accepted or once words_written+pend_v == DEPTH.
  - Encoding is combinational on accept and is registered into a one-entry pend stage.
  - imem_we rises the cycle after accept, so accept-to-write latency is 1 cycle.
  - imem_we, imem_addr and imem_wdata hold stable while imem_ready=0.
  - On write completion: imem_addr += 1 (wraps), words_written += 1.
  - Accept and completion in the same cycle are allowed, giving a sustained rate of 1 word/cycle.
- Encoding by in_op:
  - 0110011 (R): {0,f7b5,00000, rs2, rs1, f3, rd, op}
  - 0010011 (I): {imm[11:0], rs1, f3, rd, op}
  - 0000011 (lw): {imm[11:0], rs1, 010, rd, op}
  - 0100011 (sw): {imm[11:5], rs2, rs1, 010, imm[4:0], op}
  - 1100011 (B): {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op}
- Illegal descriptors: any other opcode; B-type with f3 not in {000, 001, 100}; B-type with imm[0]=1.
  - The descriptor is still accepted, but nothing is written.
  - err pulses the cycle after accept; err_cnt increments, saturating at 255.
  - in_last on an illegal descriptor still terminates the session.
- RUN -> DONE:
  - when the in_last word completes its write, or
  - the cycle after an illegal in_last is accepted with no pending write, or
  - when words_written reaches DEPTH, which also sets ovf=1.
  - In DONE: done=1, busy=0, in_ready=0, imem_we=0.

Test Plan:
- add x3,x1,x2 (op 0110011, f3 000, f7b5 0), base_addr 0x10, in_last -> imem_we the cycle after accept, addr 0x10, wdata 0x002081B3; done next cycle; words_written=1.
- Stream sub x5,x6,x7 / lw x1,8(x2) / sw x5,12(x2) / beq x1,x2,-8, back-to-back with imem_ready=1 -> 0x407302B3, 0x00812083, 0x00512623, 0xFE208CE3 at consecutive addresses, one per cycle.
- Hold imem_ready=0 for 3 cycles mid-stream -> imem_we/addr/wdata held stable, in_ready=0, no word lost or duplicated.
- Descriptors op 1101111, then a B-type with f3 010, then a B-type with imm=5 -> no writes, three err pulses, err_cnt=3, imem_addr unchanged.
- DEPTH=4, ADDR_W=8, base 0xFE, 6 descriptors without in_last -> writes at 0xFE, 0xFF, 0x00, 0x01; then done=1, ovf=1, in_ready=0.
- rst_n=0 for one edge while a write is pending with imem_ready=0 -> all outputs 0 and IDLE next cycle; a new start restarts cleanly from the new base_addr.

Source files
------------

// File: rtl/instr_encoder_loader.sv
// Encodes RV32I instruction descriptors into machine words and streams them
// into instruction memory through a one-entry pending write stage.
module instr_encoder_loader #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        in_op,
  input  logic [2:0]        in_funct3,
  input  logic              in_funct7b5,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [12:0]       in_imm,
  input  logic              in_last,
  output logic              imem_we,
  input  logic              imem_ready,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              ovf,
  output logic              err,
  output logic [7:0]        err_cnt,
  output logic [ADDR_W:0]   words_written
);

  localparam int unsigned WW = ADDR_W + 1;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LW = 7'b0000011;
  localparam logic [6:0] OP_SW = 7'b0100011;
  localparam logic [6:0] OP_B  = 7'b1100011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic          last_acc;
  logic          pend_last;
  logic [31:0]   enc_word;
  logic          enc_legal;
  logic          acc_c;
  logic          cmp_c;
  logic          cap_hit_c;
  logic [WW-1:0] ww_inc_c;
  logic          depth_hit_c;

  // Field-level descriptor to 32-bit machine word, plus legality
  always_comb begin
    enc_word  = '0;
    enc_legal = 1'b0;
    case (in_op)
      OP_R: begin
        enc_word  = {1'b0, in_funct7b5, 5'b00000, in_rs2, in_rs1, in_funct3, in_rd, in_op};
        enc_legal = 1'b1;
      end
      OP_I: begin
        enc_word  = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_op};
        enc_legal = 1'b1;
      end
      OP_LW: begin
        enc_word  = {in_imm[11:0], in_rs1, 3'b010, in_rd, in_op};
        enc_legal = 1'b1;
      end
      OP_SW: begin
        enc_word  = {in_imm[11:5], in_rs2, in_rs1, 3'b010, in_imm[4:0], in_op};
        enc_legal = 1'b1;
      end
      OP_B: begin
        enc_word  = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                     in_imm[4:1], in_imm[11], in_op};
        enc_legal = ((in_funct3 == 3'b000) || (in_funct3 == 3'b001) ||
                     (in_funct3 == 3'b100)) && !in_imm[0];
      end
      default: begin
        enc_word  = '0;
        enc_legal = 1'b0;
      end
    endcase
  end

  // Capacity counts the word still sitting in the pending stage
  assign cap_hit_c   = (words_written + WW'(imem_we)) == WW'(DEPTH);
  assign in_ready    = (state == RUN) && !last_acc && !cap_hit_c && (!imem_we || imem_ready);
  assign acc_c       = in_valid && in_ready;
  assign cmp_c       = imem_we && imem_ready;
  assign ww_inc_c    = words_written + WW'(1);
  assign depth_hit_c = (ww_inc_c == WW'(DEPTH));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      last_acc      <= 1'b0;
      pend_last     <= 1'b0;
      imem_we       <= 1'b0;
      imem_addr     <= '0;
      imem_wdata    <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      ovf           <= 1'b0;
      err           <= 1'b0;
      err_cnt       <= '0;
      words_written <= '0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state         <= RUN;
            busy          <= 1'b1;
            done          <= 1'b0;
            ovf           <= 1'b0;
            err_cnt       <= '0;
            words_written <= '0;
            imem_addr     <= base_addr;
            imem_we       <= 1'b0;
            last_acc      <= 1'b0;
            pend_last     <= 1'b0;
          end
        end
        RUN: begin
          if (cmp_c) begin
            imem_addr     <= imem_addr + ADDR_W'(1);
            words_written <= ww_inc_c;
          end
          if (acc_c && enc_legal) begin
            imem_we    <= 1'b1;
            imem_wdata <= enc_word;
            pend_last  <= in_last;
          end else if (cmp_c) begin
            imem_we <= 1'b0;
          end
          if (acc_c && !enc_legal) begin
            err <= 1'b1;
            if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
          end
          if (acc_c && in_last) last_acc <= 1'b1;

          // Session ends on the final write, or at once for an illegal last with nothing queued
          if (cmp_c && (pend_last || last_acc || depth_hit_c)) begin
            state   <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            imem_we <= 1'b0;
            ovf     <= !pend_last && depth_hit_c;
          end else if (acc_c && !enc_legal && in_last && (!imem_we || cmp_c)) begin
            state   <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            imem_we <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Bench for instr_encoder_loader: directed program loads plus randomized
// sessions checked against an arithmetic RV32I encoding model.
module tb_instr_encoder_loader;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DEPTH  = 4;
  localparam int          BUDGET = 400;

  typedef struct packed {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [12:0] imm;
    logic        last;
  } desc_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic              in_valid;
  logic              in_ready;
  logic [6:0]        in_op;
  logic [2:0]        in_funct3;
  logic              in_funct7b5;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [12:0]       in_imm;
  logic              in_last;
  logic              imem_we;
  logic              imem_ready;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              busy;
  logic              done;
  logic              ovf;
  logic              err;
  logic [7:0]        err_cnt;
  logic [ADDR_W:0]   words_written;

  instr_encoder_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_funct3(in_funct3), .in_funct7b5(in_funct7b5), .in_rd(in_rd),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_last(in_last),
    .imem_we(imem_we), .imem_ready(imem_ready), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .busy(busy), .done(done), .ovf(ovf), .err(err),
    .err_cnt(err_cnt), .words_written(words_written)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  desc_t       desc_q[$];
  logic [31:0] obs_d[$];
  logic [7:0]  obs_a[$];
  int          acc_cyc[$];
  int          wr_cyc[$];
  int          done_cyc;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic bit ref_legal(input desc_t d);
    case (d.op)
      7'h33, 7'h13, 7'h03, 7'h23: return 1'b1;
      7'h63: return ((d.f3 == 3'd0) || (d.f3 == 3'd1) || (d.f3 == 3'd4)) && (d.imm[0] == 1'b0);
      default: return 1'b0;
    endcase
  endfunction

  // Place each field at its bit position with shifts and masks
  function automatic logic [31:0] ref_enc(input desc_t d);
    int unsigned op, rd, f3, rs1, rs2, im, f7, w;
    op = 32'(d.op); rd = 32'(d.rd); f3 = 32'(d.f3);
    rs1 = 32'(d.rs1); rs2 = 32'(d.rs2); im = 32'(d.imm); f7 = 32'(d.f7);
    w = 0;
    case (d.op)
      7'h33: w = op | (rd << 7) | (f3 << 12) | (rs1 << 15) | (rs2 << 20) | (f7 << 30);
      7'h13: w = op | (rd << 7) | (f3 << 12) | (rs1 << 15) | ((im & 32'hFFF) << 20);
      7'h03: w = op | (rd << 7) | (2 << 12) | (rs1 << 15) | ((im & 32'hFFF) << 20);
      7'h23: w = op | ((im & 32'h1F) << 7) | (2 << 12) | (rs1 << 15) | (rs2 << 20)
                 | (((im >> 5) & 32'h7F) << 25);
      7'h63: w = op | (((im >> 11) & 1) << 7) | (((im >> 1) & 32'hF) << 8) | (f3 << 12)
                 | (rs1 << 15) | (rs2 << 20) | (((im >> 5) & 32'h3F) << 25)
                 | (((im >> 12) & 1) << 31);
      default: w = 0;
    endcase
    return w;
  endfunction

  function automatic desc_t mk(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                               input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [12:0] imm, input logic last);
    desc_t d;
    d.op = op; d.f3 = f3; d.f7 = f7; d.rd = rd; d.rs1 = rs1; d.rs2 = rs2;
    d.imm = imm; d.last = last;
    return d;
  endfunction

  function automatic desc_t rand_desc();
    desc_t d;
    logic [6:0] bad_ops[5];
    int k;
    bad_ops[0] = 7'h6F; bad_ops[1] = 7'h37; bad_ops[2] = 7'h17;
    bad_ops[3] = 7'h67; bad_ops[4] = 7'h73;
    d = mk(7'h00, 3'($urandom), 1'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
           13'($urandom), 1'b0);
    k = int'($urandom_range(0, 9));
    case (k)
      0, 1: d.op = 7'h33;
      2, 3: d.op = 7'h13;
      4:    d.op = 7'h03;
      5:    d.op = 7'h23;
      6, 7: begin d.op = 7'h63; d.imm[0] = 1'b0; end
      8:    d.op = 7'h63;
      default: d.op = bad_ops[$urandom_range(0, 4)];
    endcase
    return d;
  endfunction

  task automatic drive_desc(input desc_t d);
    in_op = d.op; in_funct3 = d.f3; in_funct7b5 = d.f7; in_rd = d.rd;
    in_rs1 = d.rs1; in_rs2 = d.rs2; in_imm = d.imm; in_last = d.last;
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_in_ready"}, 32'(in_ready), 0);
    check_eq({tag, "_imem_we"}, 32'(imem_we), 0);
    check_eq({tag, "_imem_addr"}, 32'(imem_addr), 0);
    check_eq({tag, "_imem_wdata"}, imem_wdata, 0);
    check_eq({tag, "_busy"}, 32'(busy), 0);
    check_eq({tag, "_done"}, 32'(done), 0);
    check_eq({tag, "_ovf"}, 32'(ovf), 0);
    check_eq({tag, "_err"}, 32'(err), 0);
    check_eq({tag, "_err_cnt"}, 32'(err_cnt), 0);
    check_eq({tag, "_words"}, 32'(words_written), 0);
  endtask

  // rdy_mode: 0 always ready, 1 random, 2 three-cycle stall at cycles 2..4
  task automatic run_session(input logic [7:0] base, input int rdy_mode,
                             input bit rand_valid, input string tag);
    logic [31:0] exp_w[$];
    int exp_acc, exp_err, n_legal, di, cyc, errs;
    bit exp_ovf, prev_stall;
    logic [7:0] prev_a;
    logic [31:0] prev_d;

    exp_acc = 0; exp_err = 0; n_legal = 0; exp_ovf = 1'b0;
    for (int i = 0; i < desc_q.size(); i++) begin
      exp_acc++;
      if (ref_legal(desc_q[i])) begin
        exp_w.push_back(ref_enc(desc_q[i]));
        n_legal++;
      end else if (exp_err < 255) begin
        exp_err++;
      end
      if (desc_q[i].last) break;
      if (n_legal == int'(DEPTH)) begin exp_ovf = 1'b1; break; end
    end

    obs_d.delete(); obs_a.delete(); acc_cyc.delete(); wr_cyc.delete();
    done_cyc = -1; errs = 0; di = 0; cyc = 0; prev_stall = 1'b0;
    prev_a = '0; prev_d = '0;

    @(negedge clk); start = 1'b1; base_addr = base;
    @(negedge clk); start = 1'b0;
    check_eq({tag, "_busy_start"}, 32'(busy), 1);

    forever begin
      if (err) errs++;
      if (prev_stall) begin
        check_eq({tag, "_hold_we"}, 32'(imem_we), 1);
        check_eq({tag, "_hold_addr"}, 32'(imem_addr), 32'(prev_a));
        check_eq({tag, "_hold_data"}, imem_wdata, prev_d);
      end
      if (done) begin done_cyc = cyc; break; end
      if (cyc >= BUDGET) begin
        check_eq({tag, "_timeout"}, 0, 1);
        break;
      end
      if (di < desc_q.size() && (!rand_valid || $urandom_range(0, 3) != 0)) begin
        in_valid = 1'b1;
        drive_desc(desc_q[di]);
      end else begin
        in_valid = 1'b0;
      end
      case (rdy_mode)
        0: imem_ready = 1'b1;
        1: imem_ready = ($urandom_range(0, 3) != 0);
        default: imem_ready = !(cyc >= 2 && cyc <= 4);
      endcase
      #1;
      if (imem_we && !imem_ready) check_eq({tag, "_stall_in_ready"}, 32'(in_ready), 0);
      prev_stall = imem_we && !imem_ready;
      prev_a = imem_addr;
      prev_d = imem_wdata;
      if (imem_we && imem_ready) begin
        obs_d.push_back(imem_wdata);
        obs_a.push_back(imem_addr);
        wr_cyc.push_back(cyc);
      end
      if (in_valid && in_ready) begin
        acc_cyc.push_back(cyc);
        di++;
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    imem_ready = 1'b0;

    check_eq({tag, "_nwrites"}, 32'(obs_d.size()), 32'(exp_w.size()));
    for (int i = 0; i < obs_d.size() && i < exp_w.size(); i++) begin
      check_eq($sformatf("%s_wdata%0d", tag, i), obs_d[i], exp_w[i]);
      check_eq($sformatf("%s_addr%0d", tag, i), 32'(obs_a[i]), 32'(8'(base + 8'(i))));
    end
    check_eq({tag, "_accepted"}, 32'(di), 32'(exp_acc));
    check_eq({tag, "_err_pulses"}, 32'(errs), 32'(exp_err));
    check_eq({tag, "_err_cnt"}, 32'(err_cnt), 32'(exp_err));
    check_eq({tag, "_words"}, 32'(words_written), 32'(exp_w.size()));
    check_eq({tag, "_ovf"}, 32'(ovf), 32'(exp_ovf));
    check_eq({tag, "_done"}, 32'(done), 1);
    check_eq({tag, "_busy_end"}, 32'(busy), 0);
    check_eq({tag, "_in_ready_end"}, 32'(in_ready), 0);
    check_eq({tag, "_we_end"}, 32'(imem_we), 0);
    check_eq({tag, "_addr_end"}, 32'(imem_addr), 32'(8'(base + 8'(exp_w.size()))));
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; base_addr = '0; in_valid = 1'b0; imem_ready = 1'b0;
    drive_desc(mk(7'h00, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 13'd0, 1'b0));
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;

    // add x3,x1,x2 single-word program
    desc_q = '{mk(7'h33, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 13'd0, 1'b1)};
    run_session(8'h10, 0, 1'b0, "add");
    if (obs_d.size() == 1 && acc_cyc.size() == 1) begin
      check_eq("add_word", obs_d[0], 32'h002081B3);
      check_eq("add_latency", 32'(wr_cyc[0]), 32'(acc_cyc[0] + 1));
      check_eq("add_done_cycle", 32'(done_cyc), 32'(wr_cyc[0] + 1));
    end else begin
      check_eq("add_shape", 32'(obs_d.size()), 1);
    end

    // sub / lw / sw / beq streamed back-to-back
    desc_q = '{mk(7'h33, 3'd0, 1'b1, 5'd5, 5'd6, 5'd7, 13'd0, 1'b0),
               mk(7'h03, 3'd5, 1'b0, 5'd1, 5'd2, 5'd0, 13'd8, 1'b0),
               mk(7'h23, 3'd7, 1'b0, 5'd0, 5'd2, 5'd5, 13'd12, 1'b0),
               mk(7'h63, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 13'h1FF8, 1'b1)};
    run_session(8'h20, 0, 1'b0, "stream");
    if (obs_d.size() == 4) begin
      check_eq("stream_w0", obs_d[0], 32'h407302B3);
      check_eq("stream_w1", obs_d[1], 32'h00812083);
      check_eq("stream_w2", obs_d[2], 32'h00512623);
      check_eq("stream_w3", obs_d[3], 32'hFE208CE3);
      check_eq("stream_rate", 32'(wr_cyc[3] - wr_cyc[0]), 3);
    end

    // Same stream with a three-cycle imem stall
    desc_q[3].last = 1'b1;
    run_session(8'h30, 2, 1'b0, "stall");

    // Three illegal descriptors
    desc_q = '{mk(7'h6F, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 13'd4, 1'b0),
               mk(7'h63, 3'd2, 1'b0, 5'd0, 5'd1, 5'd2, 13'd8, 1'b0),
               mk(7'h63, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 13'd5, 1'b1)};
    run_session(8'h44, 0, 1'b0, "illegal");

    // Depth limit with address wrap
    desc_q.delete();
    for (int i = 0; i < 6; i++)
      desc_q.push_back(mk(7'h13, 3'd0, 1'b0, 5'(i + 1), 5'd0, 5'd0, 13'(i), 1'b0));
    run_session(8'hFE, 0, 1'b0, "depth");

    // Reset while a write is stalled
    @(negedge clk); start = 1'b1; base_addr = 8'h40;
    @(negedge clk); start = 1'b0; imem_ready = 1'b0; in_valid = 1'b1;
    drive_desc(mk(7'h33, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 13'd0, 1'b1));
    @(negedge clk); in_valid = 1'b0;
    check_eq("abort_pending_we", 32'(imem_we), 1);
    @(negedge clk); rst_n = 1'b0; in_valid = 1'b1;
    @(negedge clk); rst_n = 1'b1;
    check_zero("abort");
    in_valid = 1'b0;
    desc_q = '{mk(7'h13, 3'd1, 1'b0, 5'd9, 5'd8, 5'd0, 13'h0FFF, 1'b0),
               mk(7'h33, 3'd4, 1'b0, 5'd2, 5'd3, 5'd4, 13'd0, 1'b1)};
    run_session(8'h80, 0, 1'b0, "restart");

    // Randomized sessions
    for (int s = 0; s < 25; s++) begin
      int len;
      len = int'($urandom_range(1, 8));
      desc_q.delete();
      for (int i = 0; i < len; i++) begin
        desc_q.push_back(rand_desc());
        if ($urandom_range(0, 9) == 0) desc_q[i].last = 1'b1;
      end
      desc_q[len - 1].last = 1'b1;
      run_session(8'($urandom), int'($urandom_range(0, 1)), 1'($urandom), $sformatf("rnd%0d", s));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
